// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the round-robin multiplier scheduler:
// FSM state encoding, default sizes and a width helper.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

    // Bits needed to index n items; never less than one so that
    // single-entry counters and IDs still have a legal width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans upward from rr_ptr+1 with
// wrap-around and returns the first active request as one-hot and index.
module rr_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_idx
);

    // First set bit after the pointer wins; the pointer itself is checked last.
    always_comb begin
        logic        found;
        logic [ID_W-1:0] idx;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mul_rr_scheduler.sv
// One shared iterative shift-add multiplier serving NUM_REQ requesters in
// round-robin order. Grant captures operands, WIDTH iterations follow, and
// the product is held with its owner ID until the consumer acknowledges.
module mul_rr_scheduler
    import mul_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_a,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [2*WIDTH-1:0]       op,
    output logic [ID_W-1:0]          op_id,
    output logic                     ready_out,
    input  logic                     ack_in
);

    localparam int CNT_W = clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_e              state_q,  state_d;
    logic [NUM_REQ-1:0]  gnt_q,    gnt_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q,     id_d;
    logic [WIDTH-1:0]    a_sh_q,   a_sh_d;
    logic [PW-1:0]       b_sh_q,   b_sh_d;
    logic [PW-1:0]       acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [PW-1:0]       op_q,     op_d;
    logic [ID_W-1:0]     op_id_q,  op_id_d;
    logic                ready_q,  ready_d;

    logic [NUM_REQ-1:0]  pick;
    logic [ID_W-1:0]     pick_idx;
    logic [WIDTH-1:0]    a_sel;
    logic [WIDTH-1:0]    b_sel;
    logic [PW-1:0]       acc_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // One-hot operand mux driven by the arbiter pick.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Partial sum for this iteration, including the current multiplier bit.
    always_comb begin
        acc_nxt = a_sh_q[0] ? (acc_q + b_sh_q) : acc_q;
    end

    // Next-state and datapath control for IDLE -> MUL -> DONE.
    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        op_id_d  = op_id_q;
        ready_d  = ready_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = pick;
                    a_sh_d   = a_sel;
                    b_sh_d   = {{WIDTH{1'b0}}, b_sel};
                    acc_d    = '0;
                    cnt_d    = '0;
                    id_d     = pick_idx;
                    rr_ptr_d = pick_idx;
                    state_d  = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_nxt;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    op_d    = acc_nxt;
                    op_id_d = id_q;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests are ignored here, so a re-grant can only come
                // from IDLE one edge after the acknowledge.
                if (ack_in) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            op_id_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            op_id_q  <= op_id_d;
            ready_q  <= ready_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign op        = op_q;
    assign op_id     = op_id_q;
    assign ready_out = ready_q;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler: inputs are driven and outputs
// sampled on the falling clock edge.
module tb_mul_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    logic        clk = 1'b0;
    logic        rst_a;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  op;
    logic [1:0]  op_id;
    logic        ready_out;
    logic        ack_in;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int exp_seq  [5];
    int exp_prod [4];

    mul_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .op        (op),
        .op_id     (op_id),
        .ready_out (ready_out),
        .ack_in    (ack_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt === 4'b0000 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready_out !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        req   = '0;
        ack_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Single transaction from requester idx; mask may hold extra requests
    // that are dropped together once the grant is seen.
    task automatic do_op(input int idx, input int a, input int b, input logic [3:0] mask);
        a_in[idx*4 +: 4] = 4'(a);
        b_in[idx*4 +: 4] = 4'(b);
        req    = mask;
        ack_in = 1'b1;
        wait_gnt();
        check($sformatf("op%0d_gnt", idx), gnt, 32'(1 << idx));
        req = '0;
        wait_ready();
        check($sformatf("op%0d_ready", idx), ready_out, 1);
        check($sformatf("op%0d_prod", idx), op, 32'(a * b));
        check($sformatf("op%0d_id", idx), op_id, 32'(idx));
        @(negedge clk);
        check($sformatf("op%0d_ready_drop", idx), ready_out, 0);
    endtask

    // Five back-to-back transactions with ack tied high; checks grant
    // order, the 6-cycle period and each result.
    task automatic run_seq(input logic [3:0] mask, input string name);
        int last = 0;
        req    = mask;
        ack_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt();
            check($sformatf("%s_gnt%0d", name, k), gnt, 32'(1 << exp_seq[k]));
            if (k > 0) check($sformatf("%s_period%0d", name, k), cyc - last, 6);
            last = cyc;
            wait_ready();
            check($sformatf("%s_id%0d", name, k), op_id, 32'(exp_seq[k]));
            check($sformatf("%s_prod%0d", name, k), op, 32'(exp_prod[exp_seq[k]]));
            if (k == 4) req = '0;
            @(negedge clk);
        end
        @(negedge clk);
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        req    = '0;
        a_in   = '0;
        b_in   = '0;
        ack_in = 1'b0;
        rst_a  = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready_out, 0);
        check("rst_op", op, 0);
        check("rst_op_id", op_id, 0);

        // Basic 3*5 with exact latency
        a_in[3:0] = 4'd3;
        b_in[3:0] = 4'd5;
        req       = 4'b0001;
        ack_in    = 1'b1;
        @(negedge clk);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy", busy, 1);
        req = '0;
        @(negedge clk);
        check("t1_gnt_pulse", gnt, 0);
        check("t1_ready_e1", ready_out, 0);
        @(negedge clk);
        @(negedge clk);
        check("t1_ready_e3", ready_out, 0);
        @(negedge clk);
        check("t1_ready_e4", ready_out, 1);
        check("t1_op", op, 15);
        check("t1_op_id", op_id, 0);
        @(negedge clk);
        check("t1_busy_after_ack", busy, 0);
        check("t1_ready_after_ack", ready_out, 0);

        // Boundary operands
        do_op(2, 15, 15, 4'b0100);
        do_op(3, 0, 9, 4'b1000);
        do_op(1, 9, 0, 4'b0010);

        // Round robin with all requesters held from reset
        do_reset();
        a_in = {4'd7, 4'd5, 4'd3, 4'd1};
        b_in = {4'd8, 4'd6, 4'd4, 4'd2};
        exp_prod = '{2, 12, 30, 56};
        exp_seq  = '{0, 1, 2, 3, 0};
        run_seq(4'b1111, "rr");

        // Back-pressure while requester 1 waits
        a_in[3:0] = 4'd2;
        b_in[3:0] = 4'd3;
        a_in[7:4] = 4'd5;
        b_in[7:4] = 4'd7;
        ack_in = 1'b0;
        req    = 4'b0001;
        wait_gnt();
        check("bp_gnt0", gnt, 4'b0001);
        req = 4'b0010;
        wait_ready();
        check("bp_ready", ready_out, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {gnt, ready_out, op_id, op}, {4'b0000, 1'b1, 2'd0, 8'd6});
        end
        ack_in = 1'b1;
        @(negedge clk);
        check("bp_ack_ready", ready_out, 0);
        check("bp_ack_no_gnt", gnt, 0);
        @(negedge clk);
        check("bp_regrant", gnt, 4'b0010);
        req = '0;
        wait_ready();
        check("bp_op1", op, 35);
        check("bp_op1_id", op_id, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation (cnt == 2)
        a_in[11:8] = 4'd5;
        b_in[11:8] = 4'd5;
        ack_in = 1'b1;
        req    = 4'b0100;
        wait_gnt();
        check("ar_gnt", gnt, 4'b0100);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("ar_zero", {gnt, busy, ready_out, op_id, op}, 0);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ar_no_result", {busy, ready_out}, 0);
        a_in[15:12] = 4'd1;
        b_in[15:12] = 4'd1;
        do_op(0, 6, 7, 4'b1001);

        // Fairness between requesters 1 and 3
        do_reset();
        a_in[7:4]   = 4'd2;
        b_in[7:4]   = 4'd3;
        a_in[15:12] = 4'd4;
        b_in[15:12] = 4'd5;
        exp_prod = '{0, 6, 0, 20};
        exp_seq  = '{1, 3, 1, 3, 1};
        run_seq(4'b1010, "fair");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
